// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, ROM req/ack fetch, valid/ready issue to execute.
// Optional one-entry prefetch buffer is built when FETCH_PREFETCH_EN is defined.
module fetch_unit #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              n_reset,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [7:0]        rom_data,
    output logic [3:0]        op_out,
    output logic [3:0]        im_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              jmp_en,
    input  logic [ADDR_W-1:0] jmp_addr,
    input  logic              halt_in,
    output logic              halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [ADDR_W-1:0] pc_out_q;
    logic              rom_req_q;
    logic              valid_q;
    logic              halted_q;
    logic [3:0]        op_q;
    logic [3:0]        im_q;

    logic [ADDR_W-1:0] pc_inc_d;
    logic [ADDR_W-1:0] redirect_pc_d;
    logic              accept_d;
    logic              ack_d;

`ifdef FETCH_PREFETCH_EN
    logic              buf_valid_q;
    logic [ADDR_W-1:0] buf_pc_q;
    logic [7:0]        buf_data_q;
    logic              drop_q;
    logic              pending_d;
`endif

    // Handshake qualifiers and next program counter candidates.
    always_comb begin
        pc_inc_d      = pc_q + ADDR_W'(1);
        redirect_pc_d = jmp_en ? jmp_addr : pc_q;
        accept_d      = valid_q & instr_ready;
        ack_d         = rom_req_q & rom_ack;
`ifdef FETCH_PREFETCH_EN
        pending_d     = rom_req_q & ~rom_ack;
`endif
    end

    // Fetch FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q     <= IDLE;
            pc_q        <= {ADDR_W{1'b0}};
            rom_addr_q  <= {ADDR_W{1'b0}};
            pc_out_q    <= {ADDR_W{1'b0}};
            rom_req_q   <= 1'b0;
            valid_q     <= 1'b0;
            halted_q    <= 1'b0;
            op_q        <= 4'd0;
            im_q        <= 4'd0;
`ifdef FETCH_PREFETCH_EN
            buf_valid_q <= 1'b0;
            buf_pc_q    <= {ADDR_W{1'b0}};
            buf_data_q  <= 8'd0;
            drop_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    rom_req_q  <= 1'b1;
                    rom_addr_q <= pc_q;
                    state_q    <= REQ;
                end

                REQ: begin
                    if (ack_d) begin
`ifdef FETCH_PREFETCH_EN
                        // A word fetched before a redirect is discarded; refetch at the target.
                        if (drop_q) begin
                            drop_q     <= 1'b0;
                            rom_addr_q <= pc_q;
                        end else begin
                            op_q       <= rom_data[7:4];
                            im_q       <= rom_data[3:0];
                            pc_out_q   <= pc_q;
                            pc_q       <= pc_inc_d;
                            valid_q    <= 1'b1;
                            rom_addr_q <= pc_inc_d;
                            state_q    <= ISSUE;
                        end
`else
                        op_q      <= rom_data[7:4];
                        im_q      <= rom_data[3:0];
                        pc_out_q  <= pc_q;
                        pc_q      <= pc_inc_d;
                        valid_q   <= 1'b1;
                        rom_req_q <= 1'b0;
                        state_q   <= ISSUE;
`endif
                    end
                end

                ISSUE: begin
`ifdef FETCH_PREFETCH_EN
                    if (accept_d && (halt_in || jmp_en)) begin
                        valid_q     <= 1'b0;
                        buf_valid_q <= 1'b0;
                        drop_q      <= pending_d;
                        if (halt_in) begin
                            halted_q  <= 1'b1;
                            rom_req_q <= pending_d;
                            state_q   <= HALT;
                        end else begin
                            pc_q    <= jmp_addr;
                            state_q <= REQ;
                            if (!pending_d) begin
                                rom_req_q  <= 1'b1;
                                rom_addr_q <= jmp_addr;
                            end
                        end
                    end else if (accept_d && buf_valid_q) begin
                        op_q        <= buf_data_q[7:4];
                        im_q        <= buf_data_q[3:0];
                        pc_out_q    <= buf_pc_q;
                        buf_valid_q <= 1'b0;
                        rom_req_q   <= 1'b1;
                        rom_addr_q  <= pc_q;
                    end else if (accept_d && ack_d) begin
                        op_q       <= rom_data[7:4];
                        im_q       <= rom_data[3:0];
                        pc_out_q   <= pc_q;
                        pc_q       <= pc_inc_d;
                        rom_addr_q <= pc_inc_d;
                    end else if (accept_d) begin
                        // Prefetch still in flight: wait for it in REQ.
                        valid_q <= 1'b0;
                        state_q <= REQ;
                    end else if (ack_d) begin
                        buf_valid_q <= 1'b1;
                        buf_pc_q    <= pc_q;
                        buf_data_q  <= rom_data;
                        pc_q        <= pc_inc_d;
                        rom_req_q   <= 1'b0;
                    end
`else
                    if (accept_d) begin
                        valid_q <= 1'b0;
                        // Halt wins over a simultaneous jump.
                        if (halt_in) begin
                            halted_q <= 1'b1;
                            state_q  <= HALT;
                        end else begin
                            pc_q       <= redirect_pc_d;
                            rom_addr_q <= redirect_pc_d;
                            rom_req_q  <= 1'b1;
                            state_q    <= REQ;
                        end
                    end
`endif
                end

                HALT: begin
                    state_q <= HALT;
`ifdef FETCH_PREFETCH_EN
                    if (ack_d) begin
                        rom_req_q <= 1'b0;
                        drop_q    <= 1'b0;
                    end
`endif
                end

                default: begin
                    state_q   <= IDLE;
                    rom_req_q <= 1'b0;
                    valid_q   <= 1'b0;
                end
            endcase
        end
    end

    assign rom_req     = rom_req_q;
    assign rom_addr    = rom_addr_q;
    assign op_out      = op_q;
    assign im_out      = im_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 4-bit CPU, directly upstream of the instruction decoder. Holds the program counter, fetches 8-bit instruction words from program ROM over a req/ack handshake, and presents the opcode nibble (to the decoder's `op_in`) and immediate nibble to the execute stage under a valid/ready handshake. Applies jump redirects and a halt request from execute.

## Interface
- `ADDR_W`, 4: program counter / ROM address width.
- `clk`  in  1  sole clock; all state on rising edge.
- `n_reset`  in  1  synchronous, active-low reset.
- `rom_req`  out  1  ROM read request.
- `rom_addr`  out  ADDR_W  ROM read address.
- `rom_ack`  in  1  ROM data valid this cycle; completes the request.
- `rom_data`  in  8  instruction word: [7:4] opcode, [3:0] immediate.
- `op_out`  out  4  opcode of the held instruction; feeds decoder `op_in`.
- `im_out`  out  4  immediate of the held instruction.
- `pc_out`  out  ADDR_W  address of the held instruction.
- `instr_valid`  out  1  `op_out`/`im_out`/`pc_out` are valid.
- `instr_ready`  in  1  execute accepts the held instruction this cycle.
- `jmp_en`  in  1  redirect; only meaningful in an accept cycle.
- `jmp_addr`  in  ADDR_W  redirect target.
- `halt_in`  in  1  stop fetching; only meaningful in an accept cycle.
- `halted`  out  1  fetch stopped.

## Operation
- Reset (`n_reset`=0 at an edge): `pc`=0, state IDLE, all outputs 0 (`rom_req`, `rom_addr`, `op_out`, `im_out`, `pc_out`, `instr_valid`, `halted`). Prefetch buffer (if built) empty, drop flag clear. Reset overrides everything, including an outstanding ROM request; ROM sees `rom_req` fall.
- States: IDLE, REQ, ISSUE, HALT.
- IDLE: unconditionally -> REQ next cycle.
- REQ: `rom_req`=1, `rom_addr`=`pc`, both held stable until `rom_ack`. On `rom_ack`: IR <= `rom_data`, `pc_out` <= `pc`, `pc` <= `pc`+1 (mod 2^ADDR_W; 15 wraps to 0), -> ISSUE.
- ISSUE: `instr_valid`=1, IR fields stable. Accept = `instr_valid` & `instr_ready`. On accept:
  - `halt_in`=1: -> HALT (takes priority over `jmp_en`).
  - else `jmp_en`=1: `pc` <= `jmp_addr`, -> REQ.
  - else -> REQ.
  - No accept: hold; `jmp_en`/`halt_in` ignored.
- HALT: `halted`=1, `instr_valid`=0, `rom_req`=0; exits only through reset.
- `rom_ack` outside an outstanding request is ignored.

## Timing
- `rom_ack` may be asserted in the same cycle `rom_req` first rises (combinational ROM); arbitrary wait cycles allowed.
- Without prefetch: zero-wait ROM and `instr_ready` tied high give one instruction every 2 cycles; reset release -> first `instr_valid` at cycle 3 (IDLE, REQ, ISSUE).
- `instr_valid` rises the cycle after `rom_ack`; falls the cycle after accept unless a buffered word is promoted.
- Jump: first request to `jmp_addr` appears the cycle after the accept.

## Configuration
- `FETCH_PREFETCH_EN` defined: one-entry prefetch buffer. In ISSUE with buffer empty, `rom_req`=1 at `pc`; on ack, buffer <= {`pc`, `rom_data`}, `pc` <= `pc`+1. On non-jump accept with buffer full: promote buffer to IR in the same edge, remain ISSUE (`instr_valid` stays 1; back-to-back). Ack and accept in the same cycle: the acked word goes straight to IR. On jump or halt accept: buffer discarded; if a request is outstanding, `rom_req`/`rom_addr` are held until its ack, the returned word is dropped (drop flag), then REQ at `jmp_addr`. Zero-wait ROM with `instr_ready` high sustains 1 instruction/cycle after the first.
- Undefined: no buffer, no ROM request in ISSUE; behaviour exactly as in Operation.

## Test plan
- Reset/sequential: ROM[0..2]=0x31,0x52,0x03, zero-wait, `instr_ready`=1 -> accepts {op,im,pc} = {3,1,0},{5,2,1},{0,3,2}, each 2 cycles apart (1 apart after first with `FETCH_PREFETCH_EN`).
- Backpressure: `instr_ready`=0 for 5 cycles while ISSUE -> `op_out`/`im_out`/`pc_out` unchanged, no second `rom_req` (none at all without the macro), accept on cycle 6 proceeds normally.
- ROM wait: `rom_ack` delayed 3 cycles -> `rom_addr` constant and `rom_req` high for all 4 cycles, `pc` advances only once.
- Jump/wrap: accept at `pc_out`=15 with no jump -> next fetch address 0; accept with `jmp_en`=1, `jmp_addr`=9 -> next fetched `pc_out`=9, prefetched word (macro on) never issued.
- Halt: accept with `halt_in`=1 and `jmp_en`=1 -> `halted`=1 next cycle, `instr_valid`=0, no further `rom_req`; `n_reset`=0 one cycle -> fetch restarts at 0.
- Reset mid-request: `n_reset`=0 while `rom_req`=1 and ack pending -> next cycle all outputs 0, late `rom_ack` ignored, first request after release at address 0.
